// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit hex seven-segment driver with a valid/ready shadow register and frame-boundary commit.
// Optional feature: define SEVSEG_LEAD_ZERO_BLANK_EN to suppress segments of leading-zero digits.
module seven_segment_mux #(
   parameter int N_DIGITS        = 4,
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_CYCLES    = 2,
   parameter int SEG_ACTIVE_LOW  = 1,
   parameter int DIG_ACTIVE_LOW  = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [4*N_DIGITS-1:0] in_data,
   input  logic [N_DIGITS-1:0]   in_dp,
   output logic                  in_ready,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   digit_en,
   output logic                  frame_start
);

   localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] EN_OFF  = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] shadow_q, shadow_d, display_q, display_d;
   logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, display_dp_q, display_dp_d;
   logic [N_DIGITS-1:0]   lz_q, lz_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                  frame_start_q, frame_start_d;

   logic                  wrap_slot, wrap_frame;
   logic [3:0]            nib;
   logic                  nib_dp, nib_blank;
   logic [6:0]            seg_raw;
   logic                  seen_nz;

   always_comb begin
      wrap_slot  = (cnt_q == CNT_W'(TICKS_PER_DIGIT - 1));
      wrap_frame = wrap_slot && (idx_q == IDX_W'(N_DIGITS - 1));
      cnt_d      = wrap_slot ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (wrap_slot) idx_d = wrap_frame ? '0 : idx_q + IDX_W'(1);

      // Commit needs pending, accept needs !pending: the two never collide on one edge.
      shadow_d     = shadow_q;
      shadow_dp_d  = shadow_dp_q;
      display_d    = display_q;
      display_dp_d = display_dp_q;
      lz_d         = lz_q;
      pending_d    = pending_q;
      if (wrap_frame && pending_q) begin
         display_d    = shadow_q;
         display_dp_d = shadow_dp_q;
         pending_d    = 1'b0;
`ifdef SEVSEG_LEAD_ZERO_BLANK_EN
         seen_nz = 1'b0;
         for (int k = N_DIGITS - 1; k >= 1; k--) begin
            seen_nz = seen_nz | (shadow_q[k*4 +: 4] != 4'h0);
            lz_d[k] = ~seen_nz;
         end
         lz_d[0] = 1'b0;
`endif
      end
      if (in_valid && !pending_q) begin
         shadow_d    = in_data;
         shadow_dp_d = in_dp;
         pending_d   = 1'b1;
      end

      nib       = 4'h0;
      nib_dp    = 1'b0;
      nib_blank = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib       = display_q[k*4 +: 4];
            nib_dp    = display_dp_q[k];
            nib_blank = lz_q[k];
         end
      end

      case (nib)
         4'h0: seg_raw = 7'h3F;
         4'h1: seg_raw = 7'h06;
         4'h2: seg_raw = 7'h5B;
         4'h3: seg_raw = 7'h4F;
         4'h4: seg_raw = 7'h66;
         4'h5: seg_raw = 7'h6D;
         4'h6: seg_raw = 7'h7D;
         4'h7: seg_raw = 7'h07;
         4'h8: seg_raw = 7'h7F;
         4'h9: seg_raw = 7'h6F;
         4'hA: seg_raw = 7'h77;
         4'hB: seg_raw = 7'h7C;
         4'hC: seg_raw = 7'h39;
         4'hD: seg_raw = 7'h5E;
         4'hE: seg_raw = 7'h79;
         default: seg_raw = 7'h71;
      endcase
      if (nib_blank) seg_raw = 7'h00;

      // Outputs reflect the pre-edge scan position, so they trail (idx,cnt) by one clock.
      if (cnt_q < CNT_W'(BLANK_CYCLES)) begin
         seg_d      = SEG_OFF;
         dp_d       = DP_OFF;
         digit_en_d = EN_OFF;
      end else begin
         seg_d      = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
         dp_d       = (SEG_ACTIVE_LOW != 0) ? ~nib_dp : nib_dp;
         digit_en_d = (N_DIGITS'(1) << idx_q) ^ EN_OFF;
      end
      frame_start_d = wrap_frame;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_q      <= '0;
         shadow_dp_q   <= '0;
         display_q     <= '0;
         display_dp_q  <= '0;
         lz_q          <= '0;
         pending_q     <= 1'b0;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         digit_en_q    <= EN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         shadow_dp_q   <= shadow_dp_d;
         display_q     <= display_d;
         display_dp_q  <= display_dp_d;
         lz_q          <= lz_d;
         pending_q     <= pending_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         digit_en_q    <= digit_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign in_ready    = ~pending_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign digit_en    = digit_en_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: 4 digits, 8 ticks/slot, 1 blank cycle; second instance is active-low.
module tb_seven_segment_mux;

   logic        clock = 1'b0;
   logic        reset_n, reset_n_b;
   logic        in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_dp;
   logic        in_ready, dp, frame_start;
   logic [6:0]  seg;
   logic [3:0]  digit_en;
   logic        in_ready_b, dp_b, frame_start_b;
   logic [6:0]  seg_b;
   logic [3:0]  digit_en_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   seven_segment_mux #(.N_DIGITS(4), .TICKS_PER_DIGIT(8), .BLANK_CYCLES(1),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_dp(in_dp),
      .in_ready(in_ready), .seg(seg), .dp(dp), .digit_en(digit_en), .frame_start(frame_start));

   seven_segment_mux #(.N_DIGITS(4), .TICKS_PER_DIGIT(8), .BLANK_CYCLES(1),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
      .clock(clock), .reset_n(reset_n_b), .in_valid(in_valid), .in_data(in_data), .in_dp(in_dp),
      .in_ready(in_ready_b), .seg(seg_b), .dp(dp_b), .digit_en(digit_en_b), .frame_start(frame_start_b));

   // Offer a word and hold it until the next posedge takes it; returns at the negedge after acceptance.
   task automatic send(input logic [15:0] d, input logic [3:0] p, output bit ok);
      in_data = d; in_dp = p; in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin ok = 1'b1; @(negedge clock); break; end
         @(negedge clock);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (frame_start) begin ok = 1'b1; break; end
      end
   endtask

   // Called on the frame_start negedge; samples the middle of each digit slot.
   task automatic capture(output logic [3:0][6:0] s, output logic [3:0] d, output logic [3:0][3:0] e);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         s[k] = seg; d[k] = dp; e[k] = digit_en;
         if (k < 3) repeat (8) @(negedge clock);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; reset_n_b = 1'b0; in_valid = 1'b0; in_data = '0; in_dp = '0;
      repeat (5) @(negedge clock);
      checks++; if (seg !== 7'h00)       begin errors++; $display("FAIL reset_seg got %h want 00", seg); end
      checks++; if (dp !== 1'b0)         begin errors++; $display("FAIL reset_dp got %b want 0", dp); end
      checks++; if (digit_en !== 4'h0)   begin errors++; $display("FAIL reset_en got %b want 0000", digit_en); end
      checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
      reset_n = 1'b1; reset_n_b = 1'b1;
      @(negedge clock);
      checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL first_blank got %b want 0000", digit_en); end
      @(negedge clock);
      checks++; if (digit_en !== 4'b0001) begin errors++; $display("FAIL first_digit got %b want 0001", digit_en); end
      repeat (7) @(negedge clock);
      checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL slot1_blank got %b want 0000", digit_en); end
      @(negedge clock);
      checks++; if (digit_en !== 4'b0010) begin errors++; $display("FAIL slot1_digit got %b want 0010", digit_en); end
      repeat (21) @(negedge clock);
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_early got %b want 0", frame_start); end
      @(negedge clock);
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_period got %b want 1", frame_start); end
      @(negedge clock);
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_pulse got %b want 0", frame_start); end
   endtask

   task automatic test_load;
      logic [3:0][6:0] s; logic [3:0] d; logic [3:0][3:0] e; bit ok;
      logic [3:0][6:0] exp_s;
      logic [3:0] exp_e;
      exp_s = {7'h06, 7'h5B, 7'h4F, 7'h66};
      repeat (5) @(negedge clock);
      send(16'h1234, 4'b0010, ok);
      checks++; if (!ok) begin errors++; $display("FAIL load_accept got timeout want accept"); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_busy got %b want 0", in_ready); end
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL load_frame got timeout want frame_start"); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", in_ready); end
      capture(s, d, e);
      for (int k = 0; k < 4; k++) begin
         exp_e = 4'b0001 << k;
         checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL load_seg%0d got %h want %h", k, s[k], exp_s[k]); end
         checks++; if (e[k] !== exp_e)    begin errors++; $display("FAIL load_en%0d got %b want %b", k, e[k], exp_e); end
      end
      checks++; if (d !== 4'b0010) begin errors++; $display("FAIL load_dp got %b want 0010", d); end
   endtask

   task automatic test_back_to_back;
      logic [3:0][6:0] s; logic [3:0] d; logic [3:0][3:0] e; bit ok;
      int stall_err;
      wait_frame(ok);
      repeat (3) @(negedge clock);
      send(16'hAAAA, 4'b0000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_accept_a got timeout want accept"); end
      in_data = 16'h5555; in_valid = 1'b1;
      stall_err = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (frame_start) begin ok = 1'b1; break; end
         if (in_ready !== 1'b0) stall_err++;
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_frame got timeout want frame_start"); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL b2b_stall got %0d ready cycles want 0", stall_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
      capture(s, d, e);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept_5 got ready %b want 0", in_ready); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (s[k] !== 7'h77) begin errors++; $display("FAIL b2b_aaaa%0d got %h want 77", k, s[k]); end
      end
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_frame2 got timeout want frame_start"); end
      capture(s, d, e);
      for (int k = 0; k < 4; k++) begin
         checks++; if (s[k] !== 7'h6D) begin errors++; $display("FAIL b2b_5555_%0d got %h want 6D", k, s[k]); end
      end
   endtask

   task automatic test_blank;
      bit ok;
      logic [3:0] exp_e;
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_frame got timeout want frame_start"); end
      for (int off = 1; off <= 32; off++) begin
         @(negedge clock);
         exp_e = ((off - 1) % 8 == 0) ? 4'b0000 : (4'b0001 << ((off - 1) / 8));
         checks++; if (digit_en !== exp_e) begin errors++; $display("FAIL blank_en@%0d got %b want %b", off, digit_en, exp_e); end
         if ((off - 1) % 8 == 0) begin
            checks++; if (seg !== 7'h00) begin errors++; $display("FAIL blank_seg@%0d got %h want 00", off, seg); end
         end
      end
   endtask

   task automatic test_lead_zero;
      logic [3:0][6:0] s; logic [3:0] d; logic [3:0][3:0] e; bit ok;
      logic [6:0] hi_exp;
`ifdef SEVSEG_LEAD_ZERO_BLANK_EN
      hi_exp = 7'h00;
`else
      hi_exp = 7'h3F;
`endif
      send(16'h0070, 4'b0000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lz_accept got timeout want accept"); end
      wait_frame(ok);
      capture(s, d, e);
      checks++; if (s[0] !== 7'h3F) begin errors++; $display("FAIL lz70_d0 got %h want 3F", s[0]); end
      checks++; if (s[1] !== 7'h07) begin errors++; $display("FAIL lz70_d1 got %h want 07", s[1]); end
      checks++; if (s[2] !== hi_exp) begin errors++; $display("FAIL lz70_d2 got %h want %h", s[2], hi_exp); end
      checks++; if (s[3] !== hi_exp) begin errors++; $display("FAIL lz70_d3 got %h want %h", s[3], hi_exp); end
      send(16'h0000, 4'b0000, ok);
      wait_frame(ok);
      capture(s, d, e);
      checks++; if (s[0] !== 7'h3F) begin errors++; $display("FAIL lz00_d0 got %h want 3F", s[0]); end
      checks++; if (s[1] !== hi_exp) begin errors++; $display("FAIL lz00_d1 got %h want %h", s[1], hi_exp); end
      checks++; if (s[3] !== hi_exp) begin errors++; $display("FAIL lz00_d3 got %h want %h", s[3], hi_exp); end
   endtask

   task automatic test_polarity;
      bit ok;
      send(16'h0008, 4'b0000, ok);
      wait_frame(ok);
      @(negedge clock);
      checks++; if (seg_b !== 7'h7F)      begin errors++; $display("FAIL pol_blank_seg got %h want 7F", seg_b); end
      checks++; if (digit_en_b !== 4'hF)  begin errors++; $display("FAIL pol_blank_en got %b want 1111", digit_en_b); end
      repeat (4) @(negedge clock);
      checks++; if (seg_b !== 7'h00)        begin errors++; $display("FAIL pol_seg8 got %h want 00", seg_b); end
      checks++; if (digit_en_b !== 4'b1110) begin errors++; $display("FAIL pol_en got %b want 1110", digit_en_b); end
      checks++; if (dp_b !== 1'b1)          begin errors++; $display("FAIL pol_dp got %b want 1", dp_b); end
      send(16'h0001, 4'b0001, ok);
      checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL pol_pending got %b want 0", in_ready_b); end
      repeat (2) @(negedge clock);
      reset_n_b = 1'b0;
      #1;
      checks++; if (seg_b !== 7'h7F)        begin errors++; $display("FAIL prst_seg got %h want 7F", seg_b); end
      checks++; if (dp_b !== 1'b1)          begin errors++; $display("FAIL prst_dp got %b want 1", dp_b); end
      checks++; if (digit_en_b !== 4'hF)    begin errors++; $display("FAIL prst_en got %b want 1111", digit_en_b); end
      checks++; if (in_ready_b !== 1'b1)    begin errors++; $display("FAIL prst_ready got %b want 1", in_ready_b); end
      checks++; if (frame_start_b !== 1'b0) begin errors++; $display("FAIL prst_fs got %b want 0", frame_start_b); end
      @(negedge clock);
      reset_n_b = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (frame_start_b) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL prst_frame got timeout want frame_start"); end
      repeat (5) @(negedge clock);
      checks++; if (seg_b !== 7'h40)        begin errors++; $display("FAIL prst_disp got %h want 40", seg_b); end
      checks++; if (digit_en_b !== 4'b1110) begin errors++; $display("FAIL prst_en0 got %b want 1110", digit_en_b); end
      checks++; if (dp_b !== 1'b1)          begin errors++; $display("FAIL prst_dp0 got %b want 1", dp_b); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_back_to_back;
      test_blank;
      test_lead_zero;
      test_polarity;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
